branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
EX-stage counterpart of the IF-stage branch target buffer. It carries each fetched instruction's prediction (hit, taken, target) through IF/ID and ID/EX, and compares it with the real branch outcome in EX. On a wrong prediction it raises redirect and flush to the fetch logic. It also drives the BTB write port, so this block is the single writer of BTB contents.

Parameters:
PC_W, 32, program-counter and target width
IDX_W, 8, BTB index width; index = pc[IDX_W+1:2]
TAG_W, 4, BTB tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2]
CNT_W, 32, performance counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
stall_i  in  1  freezes IF/ID and ID/EX metadata; suppresses resolution
if_valid_i  in  1  IF holds a real instruction
if_pc_i  in  PC_W  IF program counter
if_pred_hit_i  in  1  BTB flag set and tag matches
if_pred_taken_i  in  1  BTB taken prediction
if_pred_target_i  in  PC_W  BTB predicted target
ex_is_branch_i  in  1  EX instruction is a conditional branch
ex_is_jump_i  in  1  EX instruction is jal/jalr
ex_taken_i  in  1  actual branch outcome (br_comp result)
ex_target_i  in  PC_W  actual target (pc+imm or rs1+imm)
redirect_o  out  1  mispredict; fetch must load redirect_pc_o
redirect_pc_o  out  PC_W  corrected PC
flush_o  out  1  kill IF and ID instructions
btb_wr_en_o  out  1  BTB write strobe
btb_wr_idx_o  out  IDX_W  BTB write index
btb_wr_tag_o  out  TAG_W  BTB write tag
btb_wr_target_o  out  PC_W  BTB write target
btb_wr_taken_o  out  1  BTB write taken bit
perf_br_cnt_o  out  CNT_W  resolved branches/jumps (PERF_CNT_EN only)
perf_miss_cnt_o  out  CNT_W  mispredicts (PERF_CNT_EN only)

Behaviour:
- Reset (asynchronous, active-low): both metadata stages invalid; every output is 0.
- Metadata stages:
  - Each IF/ID and ID/EX stage holds {valid, pc, hit, taken, target}.
  - Capture on every edge while ~stall_i.
  - When stall_i is high, both stages hold their contents.
- resolve = ID/EX.valid & ~stall_i. It is a single cycle, and nothing fires while stalled.
- eff_taken = ex_is_jump_i | (ex_is_branch_i & ex_taken_i).
- pred_taken = hit & taken.
- Mispredict, only when resolve is high, is any of:
  - pred_taken != eff_taken;
  - pred_taken & eff_taken & (target != ex_target_i);
  - a non-branch instruction with pred_taken (alias); this is covered by the first rule, because eff_taken = 0.
- redirect_o and flush_o are combinational and equal mispredict.
- redirect_pc_o = eff_taken ? ex_target_i : ID/EX.pc + 4. It is 0 when there is no redirect.
- Flush: on the edge where mispredict is high, both stages load valid = 0. Flush has priority over capture.
- BTB update:
  - Registered, one cycle after a resolve where ex_is_branch_i | ex_is_jump_i.
  - btb_wr_en_o is a one-cycle pulse.
  - idx and tag come from ID/EX.pc; target = ex_target_i; taken = eff_taken.
  - Non-branch resolves never write.
- Back-to-back resolves give back-to-back write pulses, with no loss.
- Reset mid-operation discards any pending write pulse.
- PC + 4 wraps modulo 2^PC_W.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined:
  - perf_br_cnt_o increments on each resolve of a branch or jump.
  - perf_miss_cnt_o increments on each mispredict.
  - Both saturate at all-ones and clear on reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package bru_pkg holds:
  - the bp_meta_t packed struct {valid, pc, hit, taken, target};
  - constants PC_INC = 4, IDX_LSB = 2.
- One natural sub-module, bp_meta_stage: a single metadata register with stall and flush. It is instantiated twice (IF/ID and ID/EX).

Test Plan:
- Cold miss, taken branch: pc 0x40, hit=0, ex_taken=1, target 0x80 reaches EX -> redirect_o=1, redirect_pc_o=0x80, flush_o=1. Next cycle btb_wr_en_o=1, idx=0x10, tag=0, target=0x80, taken=1.
- Correct prediction: pc 0x40, hit=1, taken=1, target 0x80; actual taken to 0x80 -> no redirect, btb_wr_en_o pulses with taken=1.
- Predicted taken, actually not taken: pc 0x1FC -> redirect_pc_o=0x200, write taken=0.
- Alias: a non-branch at pc 0x100 with hit=1, taken=1 -> redirect_pc_o=0x104, no BTB write.
- Stall: stall_i=1 for 3 cycles while a mispredicting branch sits in ID/EX -> no redirect during the stall, exactly one redirect and one write after release. The next fetched instruction is invalidated.
- With BRU_PERF_CNT_EN: 5 branches, 2 mispredicts -> perf_br_cnt_o=5, perf_miss_cnt_o=2. Assert rst_ni low mid-run -> counters and outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// bp_meta_t carries one instruction's BTB prediction down the pipe.
package bru_pkg;

    // Width of the PC/target fields inside bp_meta_t; the top-level PC_W must match.
    localparam int BP_PC_W = 32;
    localparam int PC_INC  = 4;
    localparam int IDX_LSB = 2;

    typedef struct packed {
        logic               valid;
        logic [BP_PC_W-1:0] pc;
        logic               hit;
        logic               taken;
        logic [BP_PC_W-1:0] target;
    } bp_meta_t;

endpackage

// File: rtl/bp_meta_stage.sv
// One pipeline register for prediction metadata.
// Holds while stalled; a flush clears it and takes priority over capture.
module bp_meta_stage
    import bru_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     stall_i,
    input  logic     flush_i,
    input  bp_meta_t d_i,
    output bp_meta_t q_o
);

    bp_meta_t r_meta;

    // Metadata register: flush > stall-hold > capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= '0;
        end else if (flush_i) begin
            r_meta <= '0;
        end else if (!stall_i) begin
            r_meta <= d_i;
        end
    end

    assign q_o = r_meta;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compares the carried BTB prediction with the
// real outcome, raises redirect/flush on a mispredict and is the sole
// writer of the BTB.
// Optional build macro BRU_PERF_CNT_EN adds saturating branch/miss counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             if_valid_i,
    input  logic [PC_W-1:0]  if_pc_i,
    input  logic             if_pred_hit_i,
    input  logic             if_pred_taken_i,
    input  logic [PC_W-1:0]  if_pred_target_i,
    input  logic             ex_is_branch_i,
    input  logic             ex_is_jump_i,
    input  logic             ex_taken_i,
    input  logic [PC_W-1:0]  ex_target_i,
    output logic             redirect_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             btb_wr_en_o,
    output logic [IDX_W-1:0] btb_wr_idx_o,
    output logic [TAG_W-1:0] btb_wr_tag_o,
    output logic [PC_W-1:0]  btb_wr_target_o,
    output logic             btb_wr_taken_o,
    output logic [CNT_W-1:0] perf_br_cnt_o,
    output logic [CNT_W-1:0] perf_miss_cnt_o
);

    bp_meta_t         w_if_meta;
    bp_meta_t         w_ifid;
    bp_meta_t         w_idex;
    logic             w_resolve;
    logic             w_is_cf;
    logic             w_eff_taken;
    logic             w_pred_taken;
    logic             w_mispredict;
    logic             w_wr_req;
    logic [PC_W-1:0]  w_fallthru_pc;

    logic             r_wr_en;
    logic [IDX_W-1:0] r_wr_idx;
    logic [TAG_W-1:0] r_wr_tag;
    logic [PC_W-1:0]  r_wr_target;
    logic             r_wr_taken;

    assign w_if_meta = '{valid:  if_valid_i,
                         pc:     if_pc_i,
                         hit:    if_pred_hit_i,
                         taken:  if_pred_taken_i,
                         target: if_pred_target_i};

    bp_meta_stage u_ifid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stall_i (stall_i),
        .flush_i (w_mispredict),
        .d_i     (w_if_meta),
        .q_o     (w_ifid)
    );

    bp_meta_stage u_idex (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stall_i (stall_i),
        .flush_i (w_mispredict),
        .d_i     (w_ifid),
        .q_o     (w_idex)
    );

    assign w_resolve     = w_idex.valid & ~stall_i;
    assign w_is_cf       = ex_is_branch_i | ex_is_jump_i;
    assign w_eff_taken   = ex_is_jump_i | (ex_is_branch_i & ex_taken_i);
    assign w_pred_taken  = w_idex.hit & w_idex.taken;
    // Non-branch aliases fall out of the direction compare since eff_taken is 0.
    assign w_mispredict  = w_resolve &
                           ((w_pred_taken != w_eff_taken) |
                            (w_pred_taken & w_eff_taken & (w_idex.target != ex_target_i)));
    assign w_wr_req      = w_resolve & w_is_cf;
    assign w_fallthru_pc = w_idex.pc + PC_W'(PC_INC);

    assign redirect_o    = w_mispredict;
    assign flush_o       = w_mispredict;
    assign redirect_pc_o = w_mispredict ? (w_eff_taken ? ex_target_i : w_fallthru_pc) : '0;

    // BTB write port: one-cycle strobe after each resolved branch/jump.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_en     <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_tag    <= '0;
            r_wr_target <= '0;
            r_wr_taken  <= 1'b0;
        end else begin
            r_wr_en <= w_wr_req;
            if (w_wr_req) begin
                r_wr_idx    <= w_idex.pc[IDX_W+IDX_LSB-1:IDX_LSB];
                r_wr_tag    <= w_idex.pc[IDX_W+TAG_W+IDX_LSB-1:IDX_W+IDX_LSB];
                r_wr_target <= ex_target_i;
                r_wr_taken  <= w_eff_taken;
            end
        end
    end

    assign btb_wr_en_o     = r_wr_en;
    assign btb_wr_idx_o    = r_wr_idx;
    assign btb_wr_tag_o    = r_wr_tag;
    assign btb_wr_target_o = r_wr_target;
    assign btb_wr_taken_o  = r_wr_taken;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Saturating counters of resolved control-flow instructions and mispredicts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_wr_req && !(&r_br_cnt)) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispredict && !(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_br_cnt_o   = r_br_cnt;
    assign perf_miss_cnt_o = r_miss_cnt;
`else
    assign perf_br_cnt_o   = '0;
    assign perf_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table for isolated
// resolves, BTB write scoreboard, and sequences for stall, back-to-back
// and asynchronous reset. Define BRU_PERF_CNT_EN to check the counters.
module tb_branch_resolve_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        stall_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic        if_pred_hit_i;
    logic        if_pred_taken_i;
    logic [31:0] if_pred_target_i;
    logic        ex_is_branch_i;
    logic        ex_is_jump_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        btb_wr_en_o;
    logic [7:0]  btb_wr_idx_o;
    logic [3:0]  btb_wr_tag_o;
    logic [31:0] btb_wr_target_o;
    logic        btb_wr_taken_o;
    logic [31:0] perf_br_cnt_o;
    logic [31:0] perf_miss_cnt_o;

    branch_resolve_unit dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_i          (stall_i),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .if_pred_hit_i    (if_pred_hit_i),
        .if_pred_taken_i  (if_pred_taken_i),
        .if_pred_target_i (if_pred_target_i),
        .ex_is_branch_i   (ex_is_branch_i),
        .ex_is_jump_i     (ex_is_jump_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .btb_wr_en_o      (btb_wr_en_o),
        .btb_wr_idx_o     (btb_wr_idx_o),
        .btb_wr_tag_o     (btb_wr_tag_o),
        .btb_wr_target_o  (btb_wr_target_o),
        .btb_wr_taken_o   (btb_wr_taken_o),
        .perf_br_cnt_o    (perf_br_cnt_o),
        .perf_miss_cnt_o  (perf_miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic        br;
        logic        jmp;
        logic        ex_taken;
        logic [31:0] ex_tgt;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_wr;
        logic        exp_wr_taken;
        logic [7:0]  exp_idx;
        logic [3:0]  exp_tag;
    } vec_t;

    typedef struct {
        logic [7:0]  idx;
        logic [3:0]  tag;
        logic [31:0] target;
        logic        taken;
    } wr_t;

    vec_t vecs[9];
    wr_t  wr_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_br   = 0;
    int   exp_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_perf(input string name);
`ifdef BRU_PERF_CNT_EN
        check({name, "_br_cnt"},   64'(perf_br_cnt_o),   64'(exp_br));
        check({name, "_miss_cnt"}, 64'(perf_miss_cnt_o), 64'(exp_miss));
`else
        check({name, "_br_cnt"},   64'(perf_br_cnt_o),   64'd0);
        check({name, "_miss_cnt"}, 64'(perf_miss_cnt_o), 64'd0);
`endif
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic h,
                          input logic t, input logic [31:0] tg);
        if_valid_i = v; if_pc_i = pc; if_pred_hit_i = h;
        if_pred_taken_i = t; if_pred_target_i = tg;
    endtask

    task automatic set_ex(input logic br, input logic j, input logic t, input logic [31:0] tg);
        ex_is_branch_i = br; ex_is_jump_i = j; ex_taken_i = t; ex_target_i = tg;
    endtask

    task automatic push_wr(input logic [7:0] idx, input logic [3:0] tag,
                           input logic [31:0] tgt, input logic tk);
        wr_t e;
        e.idx = idx; e.tag = tag; e.target = tgt; e.taken = tk;
        wr_q.push_back(e);
    endtask

    // Scoreboard: every BTB write strobe must match the oldest expected write.
    always @(posedge clk_i) begin
        #2;
        if (btb_wr_en_o) begin
            if (wr_q.size() == 0) begin
                check("btb_wr_unexpected", 64'(btb_wr_en_o), 64'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("btb_wr_idx",    64'(btb_wr_idx_o),    64'(e.idx));
                check("btb_wr_tag",    64'(btb_wr_tag_o),    64'(e.tag));
                check("btb_wr_target", 64'(btb_wr_target_o), 64'(e.target));
                check("btb_wr_taken",  64'(btb_wr_taken_o),  64'(e.taken));
            end
        end
    end

    task automatic run_vec(input vec_t v, input int i);
        @(negedge clk_i); set_if(1'b1, v.pc, v.hit, v.taken, v.tgt);
        @(negedge clk_i); set_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); set_ex(v.br, v.jmp, v.ex_taken, v.ex_tgt);
        #1;
        check($sformatf("v%0d_redirect", i),    64'(redirect_o),    64'(v.exp_redir));
        check($sformatf("v%0d_flush", i),       64'(flush_o),       64'(v.exp_redir));
        check($sformatf("v%0d_redirect_pc", i), 64'(redirect_pc_o), 64'(v.exp_rpc));
        if (v.exp_wr) begin
            push_wr(v.exp_idx, v.exp_tag, v.ex_tgt, v.exp_wr_taken);
            exp_br++;
        end
        if (v.exp_redir) exp_miss++;
        @(negedge clk_i); set_ex(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check($sformatf("v%0d_wr_en", i),    64'(btb_wr_en_o), 64'(v.exp_wr));
        check($sformatf("v%0d_wr_drain", i), 64'(wr_q.size()), 64'd0);
        check($sformatf("v%0d_idle", i),     64'(redirect_o),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pc            h  t  tgt          br j  et ex_tgt       rd rpc          wr wt idx    tag
        vecs[0] = '{32'h40,       1'b0,1'b0,32'h0,    1'b1,1'b0,1'b1,32'h80,   1'b1,32'h80,  1'b1,1'b1,8'h10,4'h0};
        vecs[1] = '{32'h40,       1'b1,1'b1,32'h80,   1'b1,1'b0,1'b1,32'h80,   1'b0,32'h0,   1'b1,1'b1,8'h10,4'h0};
        vecs[2] = '{32'h1FC,      1'b1,1'b1,32'h300,  1'b1,1'b0,1'b0,32'h300,  1'b1,32'h200, 1'b1,1'b0,8'h7F,4'h0};
        vecs[3] = '{32'h100,      1'b1,1'b1,32'h180,  1'b0,1'b0,1'b0,32'h0,    1'b1,32'h104, 1'b0,1'b0,8'h00,4'h0};
        vecs[4] = '{32'h2C04,     1'b1,1'b1,32'h500,  1'b0,1'b1,1'b0,32'h600,  1'b1,32'h600, 1'b1,1'b1,8'h01,4'hB};
        vecs[5] = '{32'h80,       1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0,32'h90,   1'b0,32'h0,   1'b1,1'b0,8'h20,4'h0};
        vecs[6] = '{32'hFFFFFFFC, 1'b1,1'b1,32'h10,   1'b1,1'b0,1'b0,32'h10,   1'b1,32'h0,   1'b1,1'b0,8'hFF,4'hF};
        vecs[7] = '{32'h44,       1'b1,1'b1,32'h1000, 1'b0,1'b1,1'b0,32'h1000, 1'b0,32'h0,   1'b1,1'b1,8'h11,4'h0};
        vecs[8] = '{32'h48,       1'b1,1'b0,32'h0,    1'b1,1'b0,1'b0,32'h60,   1'b0,32'h0,   1'b1,1'b0,8'h12,4'h0};

        rst_ni = 1'b0; stall_i = 1'b0;
        set_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_ex(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst_redirect",    64'(redirect_o),      64'd0);
        check("rst_redirect_pc", 64'(redirect_pc_o),   64'd0);
        check("rst_flush",       64'(flush_o),         64'd0);
        check("rst_wr_en",       64'(btb_wr_en_o),     64'd0);
        check("rst_wr_idx",      64'(btb_wr_idx_o),    64'd0);
        check("rst_wr_target",   64'(btb_wr_target_o), 64'd0);
        check_perf("rst");
        @(negedge clk_i); rst_ni = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
        check_perf("after_vecs");

        // Mispredicting branch held in ID/EX by a 3-cycle stall; a predicted
        // younger instruction behind it must be flushed.
        @(negedge clk_i); set_if(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); set_if(1'b1, 32'h44, 1'b1, 1'b1, 32'h900);
        @(negedge clk_i); set_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        stall_i = 1'b1; set_ex(1'b1, 1'b0, 1'b1, 32'h80);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_redirect", k), 64'(redirect_o),  64'd0);
            check($sformatf("stall%0d_flush", k),    64'(flush_o),     64'd0);
            check($sformatf("stall%0d_wr_en", k),    64'(btb_wr_en_o), 64'd0);
            @(negedge clk_i);
        end
        stall_i = 1'b0;
        #1;
        check("unstall_redirect",    64'(redirect_o),    64'd1);
        check("unstall_redirect_pc", 64'(redirect_pc_o), 64'h80);
        push_wr(8'h10, 4'h0, 32'h80, 1'b1);
        exp_br++; exp_miss++;
        @(negedge clk_i); #1;
        check("unstall_wr_en",        64'(btb_wr_en_o), 64'd1);
        check("flushed_young_redir",  64'(redirect_o),  64'd0);
        @(negedge clk_i); #1;
        check("unstall_wr_single",    64'(btb_wr_en_o), 64'd0);
        check("flushed_young_redir2", 64'(redirect_o),  64'd0);
        set_ex(1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_wr_drain", 64'(wr_q.size()), 64'd0);

        // Back-to-back correctly predicted resolves produce consecutive writes.
        @(negedge clk_i); set_if(1'b1, 32'h40, 1'b1, 1'b1, 32'h80);
        @(negedge clk_i); set_if(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); set_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_ex(1'b1, 1'b0, 1'b1, 32'h80); #1;
        check("b2b0_redirect", 64'(redirect_o), 64'd0);
        push_wr(8'h10, 4'h0, 32'h80, 1'b1);
        @(negedge clk_i); set_ex(1'b1, 1'b0, 1'b0, 32'h50); #1;
        check("b2b1_redirect", 64'(redirect_o),  64'd0);
        check("b2b0_wr_en",    64'(btb_wr_en_o), 64'd1);
        push_wr(8'h11, 4'h0, 32'h50, 1'b0);
        @(negedge clk_i); set_ex(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check("b2b1_wr_en",    64'(btb_wr_en_o), 64'd1);
        @(negedge clk_i); #1;
        check("b2b_wr_end",    64'(btb_wr_en_o), 64'd0);
        check("b2b_wr_drain",  64'(wr_q.size()), 64'd0);
        exp_br += 2;
        check_perf("after_b2b");

        // Asynchronous reset while a mispredict is resolving: no pending write.
        @(negedge clk_i); set_if(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); set_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); set_ex(1'b1, 1'b0, 1'b1, 32'h80); #1;
        check("prerst_redirect", 64'(redirect_o), 64'd1);
        #1; rst_ni = 1'b0; #1;
        exp_br = 0; exp_miss = 0;
        check("async_rst_redirect",    64'(redirect_o),    64'd0);
        check("async_rst_flush",       64'(flush_o),       64'd0);
        check("async_rst_redirect_pc", 64'(redirect_pc_o), 64'd0);
        check_perf("async_rst");
        @(negedge clk_i); #1;
        check("rst_held_wr_en", 64'(btb_wr_en_o), 64'd0);
        rst_ni = 1'b1; set_ex(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); #1;
        check("post_rst_wr_en", 64'(btb_wr_en_o), 64'd0);

        // Reset while a write strobe is high drops it immediately.
        run_vec(vecs[1], 100);
        check_perf("post_rst_vec");
        @(negedge clk_i); set_if(1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); set_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i); set_ex(1'b1, 1'b0, 1'b0, 32'h90);
        push_wr(8'h20, 4'h0, 32'h90, 1'b0);
        @(negedge clk_i); set_ex(1'b0, 1'b0, 1'b0, 32'h0); #1;
        check("pulse_before_rst", 64'(btb_wr_en_o), 64'd1);
        rst_ni = 1'b0; #1;
        check("pulse_killed_by_rst", 64'(btb_wr_en_o),     64'd0);
        check("rst_clears_target",   64'(btb_wr_target_o), 64'd0);
        exp_br = 0; exp_miss = 0;
        check_perf("rst2");
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i);
        check("final_wr_drain", 64'(wr_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
